// File: rtl/mem_port_ctrl_pkg.sv
// rtl/mem_port_ctrl_pkg.sv - shared size and FSM state encodings for the memory port controller
package mem_port_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte enables, store replication, load shift/extend and misalign detection
module mem_align
  import mem_port_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  b_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    b_en      = 4'b0000;
    wdata_rep = wdata;
    ld_data   = shifted;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        b_en      = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        b_en      = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        misalign  = off[0];
      end
      SZ_WORD: begin
        b_en     = 4'b1111;
        misalign = (off != 2'b00);
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - single-outstanding core-to-memory port controller (load/store FSM)
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int addr_w = 32,
  parameter int data_w = 32
) (
  input  logic              gclk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [addr_w-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [data_w-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [data_w-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_misalign,
  output logic [addr_w-1:0] mem_addr,
  output logic [data_w-1:0] mem_wdata,
  output logic [3:0]        mem_b_en,
  output logic              mem_w_en,
  input  logic [data_w-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              mem_error
);

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d;
  logic              signed_q, signed_d;
  logic              misal_q, misal_d;
  logic              err_q, err_d;
  logic [data_w-1:0] rdata_q, rdata_d;
  logic [addr_w-1:0] mem_addr_q, mem_addr_d;
  logic [data_w-1:0] mem_wdata_q, mem_wdata_d;

  logic              idle;
  logic [1:0]        a_off, a_size;
  logic              a_signed, a_misalign;
  logic [3:0]        a_b_en;
  logic [31:0]       a_wdata, a_ld_data;

  // In IDLE the aligner looks at the incoming request; afterwards at the held one.
  assign idle     = (state_q == IDLE);
  assign a_off    = idle ? req_addr[1:0] : off_q;
  assign a_size   = idle ? req_size      : size_q;
  assign a_signed = idle ? req_signed    : signed_q;

  mem_align u_align (
    .off       (a_off),
    .size      (a_size),
    .is_signed (a_signed),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .b_en      (a_b_en),
    .wdata_rep (a_wdata),
    .ld_data   (a_ld_data),
    .misalign  (a_misalign)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    wen_d       = wen_q;
    signed_d    = signed_q;
    misal_d     = misal_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          size_d   = req_size;
          wen_d    = req_wen;
          signed_d = req_signed;
          misal_d  = a_misalign;
          err_d    = 1'b0;
          rdata_d  = '0;
          if (a_misalign) begin
            state_d = RESP;
          end else begin
            state_d     = ISSUE;
            mem_addr_d  = {req_addr[addr_w-1:2], 2'b00};
            mem_wdata_d = a_wdata;
          end
        end
      end
      ISSUE: begin
        if (!mem_stall) state_d = wen_q ? RESP : WAIT;
      end
      WAIT: begin
        if (!mem_stall) begin
          rdata_d = a_ld_data;
          err_d   = mem_error;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      wen_q       <= 1'b0;
      signed_q    <= 1'b0;
      misal_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wen_q       <= wen_d;
      signed_q    <= signed_d;
      misal_q     <= misal_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready    = resetn && idle;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_b_en     = (state_q == ISSUE || state_q == WAIT) ? a_b_en : 4'b0000;
  assign mem_w_en     = (state_q == ISSUE) && wen_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rsp_valid ? rdata_q : '0;
  assign rsp_misalign = rsp_valid && misal_q;
  // Stores report the error the memory is driving in RESP; loads report the captured one.
  assign rsp_error    = rsp_valid && !misal_q && (wen_q ? mem_error : err_q);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - randomized self-checking bench for mem_port_ctrl against a byte-level memory model
module tb_mem_port_ctrl;

  logic        gclk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_misalign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_b_en;
  logic        mem_w_en;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_error;

  int total = 0;
  int bad   = 0;

  always #5 gclk = ~gclk;

  mem_port_ctrl dut (
    .gclk         (gclk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .rsp_misalign (rsp_misalign),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_b_en     (mem_b_en),
    .mem_w_en     (mem_w_en),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .mem_error    (mem_error)
  );

  function automatic logic [31:0] seed_word(int i);
    return (32'h9E3779B1 * (i + 1)) ^ 32'h5A5A0F0F;
  endfunction

  // Memory the DUT talks to: 64 words, anything at or above byte 256 reports an error.
  logic [31:0] env_mem [0:63];
  logic        env_ready = 1'b0;

  assign mem_error = (mem_addr >= 32'd256);
  assign mem_rdata = mem_error ? 32'h0 : env_mem[mem_addr[7:2]];

  always @(posedge gclk) begin
    if (!env_ready) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= seed_word(i);
      env_ready <= 1'b1;
    end else if (mem_w_en && !mem_stall && !mem_error) begin
      for (int b = 0; b < 4; b++)
        if (mem_b_en[b]) env_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference contents, one byte per address.
  logic [7:0] ref_mem [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                        input logic sgn, input logic [31:0] wdata, input int n1_in, input int n2_in);
    int          nb, lat, n1, n2;
    logic        mis, err, stall;
    logic [3:0]  be;
    logic [31:0] wrep, rexp, ext;
    nb  = 1 << size;
    mis = (size == 2'd3) || ((addr % nb) != 0);
    err = !mis && (addr >= 32'd256);
    n1  = mis ? 0 : n1_in;
    n2  = (mis || wen) ? 0 : n2_in;
    lat = mis ? 1 : (wen ? 2 + n1 : 3 + n1 + n2);
    be  = 4'((((1 << nb) - 1) << addr[1:0]) & 15);
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % nb) +: 8];
    rexp = 32'h0;
    if (!mis && !wen && !err) begin
      for (int j = 0; j < nb && j < 4; j++) rexp = rexp | (32'(ref_mem[addr[7:0] + 8'(j)]) << (8 * j));
      if (sgn && nb < 4 && rexp[8*nb-1]) begin
        ext  = 32'hFFFF_FFFF << (8 * nb);
        rexp = rexp | ext;
      end
    end

    req_valid  = 1'b1;
    req_wen    = wen;
    req_size   = size;
    req_addr   = addr;
    req_signed = sgn;
    req_wdata  = wdata;
    mem_stall  = 1'b0;
    @(negedge gclk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge gclk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_size   = 2'($urandom_range(0, 3));
    req_wen    = 1'($urandom_range(0, 1));
    req_signed = 1'($urandom_range(0, 1));
    for (int k = 1; k <= lat; k++) begin
      stall = (k <= n1) || (k >= n1 + 2 && k <= n1 + 1 + n2);
      mem_stall = stall;
      @(negedge gclk);
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, (k == lat)});
      check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (k < lat) begin
        check("mem_b_en", {28'b0, mem_b_en}, {28'b0, be});
        check("mem_w_en", {31'b0, mem_w_en}, {31'b0, (wen && k <= n1 + 1)});
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_wdata", mem_wdata, wrep);
      end else begin
        check("mem_b_en_resp", {28'b0, mem_b_en}, 32'd0);
        check("rsp_rdata", rsp_rdata, rexp);
        check("rsp_error", {31'b0, rsp_error}, {31'b0, err});
        check("rsp_misalign", {31'b0, rsp_misalign}, {31'b0, mis});
      end
      @(posedge gclk);
      #1;
    end
    mem_stall = 1'b0;
    @(negedge gclk);
    check("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    @(posedge gclk);
    #1;
    if (wen && !mis && !err)
      for (int j = 0; j < nb; j++) ref_mem[addr[7:0] + 8'(j)] = wdata[8*j +: 8];
  endtask

  initial begin
    logic        wen, sgn;
    logic [1:0]  size;
    logic [31:0] addr;

    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = seed_word(i) >> (8 * b);

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_wen    = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_wdata  = 32'h0;
    mem_stall  = 1'b0;
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mem_b_en", {28'b0, mem_b_en}, 32'd0);
    check("rst_mem_w_en", {31'b0, mem_w_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge gclk);
    resetn = 1'b1;
    @(posedge gclk);
    #1;
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);

    do_req(1'b1, 2'd2, 32'h10, 1'b0, 32'hDEADBEEF, 0, 0);
    do_req(1'b0, 2'd2, 32'h10, 1'b0, 32'h0, 0, 0);
    do_req(1'b1, 2'd0, 32'h13, 1'b0, 32'h12345680, 0, 0);
    do_req(1'b0, 2'd0, 32'h13, 1'b1, 32'h0, 0, 0);
    do_req(1'b0, 2'd0, 32'h13, 1'b0, 32'h0, 0, 0);
    do_req(1'b0, 2'd1, 32'h11, 1'b0, 32'h0, 2, 2);
    do_req(1'b0, 2'd2, 32'h20, 1'b0, 32'h0, 3, 0);
    do_req(1'b0, 2'd2, 32'h1000, 1'b0, 32'h0, 0, 1);
    do_req(1'b1, 2'd1, 32'h2002, 1'b0, 32'hCAFEF00D, 1, 0);
    do_req(1'b0, 2'd3, 32'h40, 1'b0, 32'h0, 0, 0);

    // Reset while the load sits in WAIT.
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    @(posedge gclk);
    #1;
    req_valid = 1'b0;
    @(posedge gclk);
    #1;
    mem_stall = 1'b1;
    @(negedge gclk);
    check("wait_b_en", {28'b0, mem_b_en}, 32'hF);
    resetn = 1'b0;
    #1;
    check("arst_b_en", {28'b0, mem_b_en}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd0);
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) begin
      @(negedge gclk);
      check("arst_hold_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    resetn    = 1'b1;
    mem_stall = 1'b0;
    @(posedge gclk);
    #1;
    check("arst_rel_ready", {31'b0, req_ready}, 32'd1);
    @(negedge gclk);
    check("arst_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge gclk);
    #1;

    for (int t = 0; t < 80; t++) begin
      wen  = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 4095)) : 32'($urandom_range(0, 255));
      if (size != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
      do_req(wen, size, addr, sgn, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter addr_w, default 32, address width.
REQ-002 SHALL have parameter data_w, default 32, data width; only 32 is supported.
REQ-003 SHALL have port gclk, input, 1, clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, core request strobe.
REQ-006 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-007 SHALL have port req_addr, input, addr_w, byte address.
REQ-008 SHALL have port req_wen, input, 1, 1=store, 0=load.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_signed, input, 1, sign-extend load data.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 32, aligned and extended load data; 0 for stores.
REQ-014 SHALL have port rsp_error, output, 1, memory reported an error.
REQ-015 SHALL have port rsp_misalign, output, 1, misaligned or illegal request.
REQ-016 SHALL have memory ports: mem_addr (out, addr_w), mem_wdata (out, 32), mem_b_en (out, 4), mem_w_en (out, 1), mem_rdata (in, 32), mem_stall (in, 1), mem_error (in, 1).

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-018 SHALL, on acceptance, register addr, wen, size, signed and wdata; in IDLE, a misaligned request SHALL go to RESP, otherwise the FSM SHALL go to ISSUE.
REQ-019 Misaligned SHALL mean: half with addr[0]=1; word with addr[1:0]!=0; size=11 always. It SHALL produce no memory access and SHALL give rsp_misalign=1, rsp_error=0, rsp_rdata=0.
REQ-020 SHALL drive mem_addr = {addr[addr_w-1:2], 2'b00}.
REQ-021 Byte enables SHALL be 1<<addr[1:0] for byte, 0011/1100 by addr[1] for half, and 1111 for word.
REQ-022 mem_wdata SHALL be byte replicated x4, half replicated x2, or word unchanged.
REQ-023 ISSUE: SHALL drive mem_b_en, and mem_w_en=wen. If mem_stall, the FSM SHALL stay with all memory outputs stable. Otherwise a store SHALL go to RESP and a load to WAIT.
REQ-024 WAIT (loads only): SHALL keep mem_b_en asserted with mem_w_en=0. If mem_stall, it SHALL stay. Otherwise, at the edge leaving WAIT, it SHALL capture mem_rdata and mem_error into internal registers and go to RESP.
REQ-025 Load result SHALL be mem_rdata shifted right by 8*addr[1:0], then zero- or sign-extended from bit 7 (byte) or bit 15 (half) per req_signed.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_error SHALL be the captured error for loads, or mem_error sampled in RESP for stores.
REQ-027 Outside ISSUE/WAIT, mem_b_en=0 and mem_w_en=0; mem_addr/mem_wdata SHALL hold their last values.
REQ-028 Latency from the accept edge to rsp_valid SHALL be: load 3 cycles, store 2, misaligned 1; each mem_stall cycle SHALL add 1.
REQ-029 rsp_rdata/rsp_error/rsp_misalign SHALL be valid only while rsp_valid, and zero otherwise.
REQ-030 A new request SHALL be accepted no earlier than the cycle after RESP; there is no back-to-back overlap.

Reset
REQ-031 resetn low SHALL immediately force state IDLE; req_ready=0 while in reset, 1 after release. All other outputs and internal registers SHALL be 0.
REQ-032 Reset mid-operation SHALL abort the request with no rsp_valid; memory enables SHALL drop asynchronously.

Structure
REQ-033 A shared header SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encodings.
REQ-034 A combinational sub-module mem_align SHALL compute byte enables, store replication, load shift/extension and the misalign flag; mem_port_ctrl SHALL contain the FSM and registers.

Verification
REQ-035 Store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_b_en=1111 on both accesses; rsp_rdata=0xDEADBEEF, 3 cycles after accept.
REQ-036 Store byte 0x80 @0x13 -> mem_wdata=0x80808080, b_en=1000. Load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-037 Load half @0x11 -> rsp_valid with rsp_misalign=1 one cycle after accept; mem_b_en stays 0 throughout.
REQ-038 mem_stall high for 3 cycles in ISSUE -> memory outputs stable; load rsp_valid 6 cycles after accept.
REQ-039 Load @ address beyond memory size -> rsp_valid with rsp_error=1.
REQ-040 resetn low during WAIT -> mem_b_en=0 immediately; no rsp_valid; req_ready=1 in the first cycle after release.
